// File: rtl/ps2_rx_frame_pkg.sv
// ps2_rx_frame_pkg: FSM encoding, frame constants and scan codes shared by the PS/2 receiver and its decoder.
package ps2_rx_frame_pkg;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ONE   = 8'h16;
    localparam logic [7:0] SC_TWO   = 8'h1E;
    localparam logic [7:0] SC_BREAK = 8'hF0;
endpackage

// File: rtl/ps2_rx_frame_if.sv
// ps2_rx_frame_if: raw PS/2 line plus the decoded byte and its strobes.
interface ps2_rx_frame_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] last_data_received;
    logic       key_pressed;
    logic       parity_error;
    logic       frame_error;
    modport master (output PS2_CLK, PS2_DAT, input last_data_received, key_pressed, parity_error, frame_error);
    modport slave (input PS2_CLK, PS2_DAT, output last_data_received, key_pressed, parity_error, frame_error);
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronises PS2_CLK/PS2_DAT, debounces the clock and emits a one-cycle pulse on its filtered falling edge.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic dat,
    output logic fall
);
    localparam int CW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
    logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d, fall_q, fall_d, flip;
    // cnt_q counts earlier samples at the new level; the current one completes the run
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_dat};
        flip       = clk_sync_q[1] != filt_q && cnt_q == CW'(FILTER_LEN - 1);
        cnt_d      = (clk_sync_q[1] == filt_q || flip) ? '0 : cnt_q + 1'b1;
        filt_d     = flip ? clk_sync_q[1] : filt_q;
        fall_d     = flip && !clk_sync_q[1];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            cnt_q      <= '0;
            filt_q     <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            fall_q     <= fall_d;
        end
    end
    assign dat  = dat_sync_q[1];
    assign fall = fall_q;
endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: deframes 11-bit PS/2 device-to-host frames into scan-code bytes with parity, stop-bit and timeout checks.
module ps2_rx_frame
    import ps2_rx_frame_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic           CLOCK_50,
    input logic           reset,
    ps2_rx_frame_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic                 dat, fall, timeout;
    logic [1:0]           state_q, state_d, bit_q, bit_d_unused;
    logic [2:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 par_q, par_d, key_q, key_d, perr_q, perr_d, ferr_q, ferr_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    assign bit_q        = state_q;
    assign bit_d_unused = bit_q;
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk(CLOCK_50), .rst(reset), .ps2_clk(bus.PS2_CLK), .ps2_dat(bus.PS2_DAT), .dat(dat), .fall(fall)
    );
    // a timeout wins over a fall pulse landing in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        key_d   = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        timeout = state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1);
        tmo_d   = (timeout || fall || state_q == ST_IDLE) ? '0 : tmo_q + 1'b1;
        if (timeout) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = dat ? ST_IDLE : ST_DATA;
                    cnt_d   = '0;
                end
                ST_DATA: begin
                    shift_d = {dat, shift_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    state_d = cnt_q == 3'(DATA_BITS - 1) ? ST_PARITY : ST_DATA;
                end
                ST_PARITY: begin
                    par_d   = dat;
                    state_d = ST_STOP;
                end
                default: begin
                    key_d   = dat && ^{shift_q, par_q};
                    perr_d  = dat && !(^{shift_q, par_q});
                    ferr_d  = !dat;
                    data_d  = key_d ? shift_q : data_q;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            key_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            key_q   <= key_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            tmo_q   <= tmo_d;
        end
    end
    assign bus.last_data_received = data_q;
    assign bus.key_pressed        = key_q;
    assign bus.parity_error       = perr_q;
    assign bus.frame_error        = ferr_q;
endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: scoreboard bench; expected strobes are queued as frames are driven and matched against observed strobes.
module tb_ps2_rx_frame;
    import ps2_rx_frame_pkg::*;
    localparam int FL = 8;
    localparam int TO = 400;
    localparam int H  = 40;
    localparam logic [1:0] K_KEY = 2'd0, K_PERR = 2'd1, K_FERR = 2'd2, K_MULTI = 2'd3;
    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;
    logic clk = 1'b0;
    logic reset;
    ev_t  exp_q[$], obs_q[$];
    ev_t  e, o;
    int   cyc = 0, stop_cyc = 0, n_checks = 0, n_fail = 0;
    logic [7:0] last_good = 8'h00;
    always #10 clk = ~clk;
    ps2_rx_frame_if bus();
    ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (.CLOCK_50(clk), .reset(reset), .bus(bus.slave));

    task automatic wait_cycles(input int n);
        int s;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            s = int'(bus.key_pressed) + int'(bus.parity_error) + int'(bus.frame_error);
            if (s > 0)
                obs_q.push_back('{kind: s > 1 ? K_MULTI : bus.key_pressed ? K_KEY : bus.parity_error ? K_PERR : K_FERR,
                                  data: bus.last_data_received, cyc: cyc});
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.PS2_DAT = bits[i];
            wait_cycles(H);
            bus.PS2_CLK = 1'b0;
            if (i == FRAME_BITS - 1) stop_cyc = cyc;
            wait_cycles(H);
            bus.PS2_CLK = 1'b1;
        end
        bus.PS2_DAT = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        if (!stop) exp_q.push_back('{kind: K_FERR, data: last_good, cyc: 0});
        else if (^{d, par}) begin
            last_good = d;
            exp_q.push_back('{kind: K_KEY, data: d, cyc: 0});
        end else exp_q.push_back('{kind: K_PERR, data: last_good, cyc: 0});
        send_bits({stop, par, d, 1'b0}, FRAME_BITS);
        wait_cycles(2 * H);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);
        obs_q.delete();
        n_checks++;
        if (bus.last_data_received !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.last_data_received); end
        n_checks++;
        if ({bus.key_pressed, bus.parity_error, bus.frame_error} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 000", {bus.key_pressed, bus.parity_error, bus.frame_error});
        end
        n_checks++;
        if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_single;
        send_frame(SC_SPACE, 1'b0, 1'b1);
        n_checks++;
        if (obs_q.size() == 0 || obs_q[0].cyc - stop_cyc != FL + 3) begin
            n_fail++; $display("FAIL single_latency: got %0d cycles expected %0d", obs_q.size() ? obs_q[0].cyc - stop_cyc : -1, FL + 3);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL single: no strobe, expected kind %0d data %h", e.kind, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.data !== e.data) begin
                    n_fail++; $display("FAIL single: got kind %0d data %h expected kind %0d data %h", o.kind, o.data, e.kind, e.data);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL single_extra: got %0d extra strobes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back;
        send_frame(SC_BREAK, 1'b1, 1'b1);
        send_frame(SC_ENTER, 1'b1, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b: no strobe, expected kind %0d data %h", e.kind, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.data !== e.data) begin
                    n_fail++; $display("FAIL b2b: got kind %0d data %h expected kind %0d data %h", o.kind, o.data, e.kind, e.data);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra strobes expected 0", obs_q.size()); obs_q.delete(); end
        n_checks++;
        if (bus.last_data_received !== 8'h5A) begin n_fail++; $display("FAIL b2b_hold: got %h expected 5a", bus.last_data_received); end
    endtask

    task automatic test_parity_error;
        send_frame(SC_ONE, 1'b1, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL parity: no strobe, expected kind %0d data %h", e.kind, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.data !== e.data) begin
                    n_fail++; $display("FAIL parity: got kind %0d data %h expected kind %0d data %h", o.kind, o.data, e.kind, e.data);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL parity_extra: got %0d extra strobes expected 0", obs_q.size()); obs_q.delete(); end
        n_checks++;
        if (bus.last_data_received !== 8'h5A) begin n_fail++; $display("FAIL parity_hold: got %h expected 5a", bus.last_data_received); end
    endtask

    task automatic test_frame_error;
        send_frame(SC_TWO, 1'b1, 1'b0);
        send_frame(SC_TWO, 1'b1, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL frame: no strobe, expected kind %0d data %h", e.kind, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.data !== e.data) begin
                    n_fail++; $display("FAIL frame: got kind %0d data %h expected kind %0d data %h", o.kind, o.data, e.kind, e.data);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL frame_extra: got %0d extra strobes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_timeout;
        exp_q.push_back('{kind: K_FERR, data: last_good, cyc: 0});
        send_bits({2'b11, SC_SPACE, 1'b0}, 5);
        wait_cycles(TO + 100);
        n_checks++;
        if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL timeout_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
        send_frame(SC_SPACE, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL timeout: no strobe, expected kind %0d data %h", e.kind, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.data !== e.data) begin
                    n_fail++; $display("FAIL timeout: got kind %0d data %h expected kind %0d data %h", o.kind, o.data, e.kind, e.data);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL timeout_extra: got %0d extra strobes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_glitch_reset;
        for (int i = 0; i < 3; i++) begin
            bus.PS2_CLK = 1'b0;
            wait_cycles(3);
            bus.PS2_CLK = 1'b1;
            wait_cycles(20);
        end
        send_bits({2'b11, SC_ENTER, 1'b0}, 6);
        reset = 1'b1;
        wait_cycles(2);
        n_checks++;
        if ({bus.last_data_received, bus.key_pressed, bus.parity_error, bus.frame_error} !== 11'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got data %h strobes %b expected 00 000", bus.last_data_received,
                               {bus.key_pressed, bus.parity_error, bus.frame_error});
        end
        reset = 1'b0;
        last_good = 8'h00;
        wait_cycles(2 * H);
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_strobes: got %0d strobes expected 0", obs_q.size()); obs_q.delete(); end
        send_frame(SC_TWO, 1'b1, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL resync: no strobe, expected kind %0d data %h", e.kind, e.data); end
            else begin
                o = obs_q.pop_front();
                if (o.kind !== e.kind || o.data !== e.data) begin
                    n_fail++; $display("FAIL resync: got kind %0d data %h expected kind %0d data %h", o.kind, o.data, e.kind, e.data);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL resync_extra: got %0d extra strobes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity_error();
        test_frame_error();
        test_timeout();
        test_glitch_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
